operand_mult_ctrl: RTL and testbench

- Upstream feeder for segment_7.
- Captures two 4-bit operands from slide switches on successive presses of an enter button, then multiplies them with a sequential shift-add datapath.
- Drives the operands and the 8-bit product onto segment_7's data1, data2 and data3 inputs.
- Shares segment_7's clk and reset.

---
 rtl/operand_mult_ctrl_if.sv | 24 ++
 rtl/operand_mult_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_operand_mult_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_mult_ctrl_if.sv
// Purpose: bundles the operand switches, the enter button and the segment_7-facing
//          results (data1/data2/data3, busy, done) of operand_mult_ctrl.
// Ports:   master = switch/button side (drives sw, btn_enter); slave = operand_mult_ctrl.
interface operand_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   sw;
    logic               btn_enter;
    logic [WIDTH-1:0]   data1;
    logic [WIDTH-1:0]   data2;
    logic [2*WIDTH-1:0] data3;
    logic               busy;
    logic               done;

    modport master (
        output sw, btn_enter,
        input  data1, data2, data3, busy, done
    );

    modport slave (
        input  sw, btn_enter,
        output data1, data2, data3, busy, done
    );
endinterface

// File: rtl/operand_mult_ctrl.sv
// Purpose: captures operand A then B from slide switches on enter presses, multiplies
//          them with a shift-add datapath and drives A, B and A*B to segment_7.
// Latency: press acted on 3 edges after btn rise (DEBOUNCE_CYCLES+3 with debounce);
//          product valid WIDTH edges after the B press. Presses while busy are dropped.
// Ports:   clk, reset (async, active-high); bus (slave): sw, btn_enter in;
//          data1, data2, data3, busy, done out.
// Option:  define OPERAND_MULT_DEBOUNCE_EN to insert a debounce filter on the button.
module operand_mult_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    operand_mult_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Empty marker block: flags a filter length too short to mean anything.
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_cycles_too_short
    end

    // ------------------------------------------------------------------
    // Button path: 2-FF synchronizer, optional debounce, rising-edge detect
    // ------------------------------------------------------------------
    logic btn_sync1, btn_sync2;
    logic press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
        end else begin
            btn_sync1 <= bus.btn_enter;
            btn_sync2 <= btn_sync1;
        end
    end

`ifdef OPERAND_MULT_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic           btn_clean, btn_clean_q;
    logic [DBW-1:0] db_cnt;

    // The clean level only follows the synced level after it has disagreed for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_clean   <= 1'b0;
            btn_clean_q <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_clean_q <= btn_clean;
            if (btn_sync2 == btn_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_clean <= btn_sync2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    assign press = btn_clean & ~btn_clean_q;
`else
    logic btn_sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_sync2_q <= 1'b0;
        else       btn_sync2_q <= btn_sync2;
    end

    assign press = btn_sync2 & ~btn_sync2_q;
`endif

    // ------------------------------------------------------------------
    // FSM and shift-add datapath
    // ------------------------------------------------------------------
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   data1_q, data1_nxt;
    logic [WIDTH-1:0]   data2_q, data2_nxt;
    logic [2*WIDTH-1:0] data3_q, data3_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic [2*WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt, acc_step;
    logic [CW-1:0]      iter, iter_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_A;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        data1_nxt  = data1_q;
        data2_nxt  = data2_q;
        data3_nxt  = data3_q;
        busy_nxt   = busy_q;
        done_nxt   = done_q;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        iter_nxt   = iter;
        acc_step   = acc + (mplier[0] ? mcand : '0);

        case (state)
            S_A: begin
                if (press) begin
                    data1_nxt = bus.sw;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    data2_nxt  = bus.sw;
                    mcand_nxt  = {{WIDTH{1'b0}}, data1_q};
                    mplier_nxt = bus.sw;
                    acc_nxt    = '0;
                    iter_nxt   = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_MUL;
                end
            end
            S_MUL: begin
                // press is ignored here on purpose: nothing is queued.
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                iter_nxt   = iter + CW'(1);
                if (iter == CW'(WIDTH - 1)) begin
                    // Only the finished sum is ever written to data3.
                    data3_nxt = acc_step;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (press) begin
                    data1_nxt = bus.sw;
                    data3_nxt = '0;
                    done_nxt  = 1'b0;
                    state_nxt = S_B;
                end
            end
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            iter    <= '0;
        end else begin
            data1_q <= data1_nxt;
            data2_q <= data2_nxt;
            data3_q <= data3_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            acc     <= acc_nxt;
            iter    <= iter_nxt;
        end
    end

    // Outputs come straight from flops so segment_7 never sees a glitch.
    assign bus.data1 = data1_q;
    assign bus.data2 = data2_q;
    assign bus.data3 = data3_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_operand_mult_ctrl.sv
module tb_operand_mult_ctrl;
    localparam int W = 4;
`ifdef OPERAND_MULT_DEBOUNCE_EN
    localparam int HOLD = 40;
    localparam int LAT  = 19;
`else
    localparam int HOLD = 4;
    localparam int LAT  = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_mult_ctrl_if #(.WIDTH(W)) bus ();

    operand_mult_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: the product is plain unsigned arithmetic on the captured operands.
    function automatic exp_t make_exp(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.p = 8'(int'(a) * int'(b));
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic mon_done_q = 1'b0;
    int   busy_cnt   = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset) begin
            mon_done_q = 1'b0;
            busy_cnt   = 0;
        end else begin
            if (bus.done && !mon_done_q) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data1", 32'(bus.data1), 32'(mon_e.a));
                    check("data2", 32'(bus.data2), 32'(mon_e.b));
                    check("data3", 32'(bus.data3), 32'(mon_e.p));
                    check("busy_cycles", 32'(busy_cnt), 32'(W));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                end
                busy_cnt = 0;
            end
            if (bus.busy) busy_cnt++;
            else          busy_cnt = 0;
            mon_done_q = bus.done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] v);
        @(negedge clk);
        bus.sw        = v;
        bus.btn_enter = 1'b1;
        repeat (HOLD) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.sw        = 4'($urandom_range(15));
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_done(input int prev, input string name);
        int t = 0;
        while (done_cnt == prev && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == prev) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic mult(input logic [3:0] a, input logic [3:0] b);
        int   prev     = done_cnt;
        logic was_done = bus.done;
        press(a);
        if (was_done) begin
            check("clear_data3", 32'(bus.data3), 32'd0);
            check("clear_done", 32'(bus.done), 32'd0);
        end
        exp_q.push_back(make_exp(a, b));
        press(b);
        wait_done(prev, "mult");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data1"}, 32'(bus.data1), 32'd0);
        check({tag, "_data2"}, 32'(bus.data2), 32'd0);
        check({tag, "_data3"}, 32'(bus.data3), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),  32'd0);
        check({tag, "_done"},  32'(bus.done),  32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a, b, v, d1;
        int         prev, t;

        reset         = 1'b1;
        bus.sw        = '0;
        bus.btn_enter = 1'b0;
        // 200 ns of reset with the button bouncing around
        for (int i = 0; i < 20; i++) begin
            #10;
            bus.btn_enter = ~bus.btn_enter;
            bus.sw        = 4'($urandom_range(15));
        end
        check_zero("in_reset");
        bus.btn_enter = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_zero("after_reset");

        // basic and boundary products (first one also proves the FSM stayed in S_A)
        mult(4'd13, 4'd10);
        mult(4'd15, 4'd15);
        mult(4'd0, 4'd9);
        mult(4'd1, 4'd15);

        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            mult(a, b);
        end

        // press-to-capture latency, starting in S_DONE
        v = 4'($urandom_range(15));
        @(negedge clk);
        bus.sw        = v;
        bus.btn_enter = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("lat_early_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("lat_done_cleared", 32'(bus.done), 32'd0);
        check("lat_data1", 32'(bus.data1), 32'(v));
        repeat (HOLD - LAT) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        prev = done_cnt;
        b    = 4'($urandom_range(15));
        exp_q.push_back(make_exp(v, b));
        press(b);
        wait_done(prev, "lat_mult");

`ifndef OPERAND_MULT_DEBOUNCE_EN
        // second press while multiplying must be dropped, not queued
        prev = done_cnt;
        press(4'd3);
        exp_q.push_back(make_exp(4'd3, 4'd7));
        @(negedge clk);
        bus.sw        = 4'd7;
        bus.btn_enter = 1'b1;
        @(negedge clk);
        bus.btn_enter = 1'b0;
        @(negedge clk);
        bus.btn_enter = 1'b1;
        @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.sw        = 4'hC;
        wait_done(prev, "busy_press");
        repeat (6) @(negedge clk);
        check("busy_press_done_held", 32'(bus.done), 32'd1);
        check("busy_press_data1", 32'(bus.data1), 32'd3);
`endif

        // reset on the second multiply cycle aborts everything
        press(4'd5);
        @(negedge clk);
        bus.sw        = 4'd6;
        bus.btn_enter = 1'b1;
        t = 0;
        while (!bus.busy && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.busy) check("abort_busy_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("abort");
        bus.btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (HOLD) @(negedge clk);
        check_zero("abort_settled");
        mult(4'd9, 4'd9);

`ifdef OPERAND_MULT_DEBOUNCE_EN
        // a 10-cycle glitch must not be taken as a press
        d1 = bus.data1;
        @(negedge clk);
        bus.sw        = ~d1;
        bus.btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_done_held", 32'(bus.done), 32'd1);
        check("glitch_data1", 32'(bus.data1), 32'(d1));
`else
        d1 = bus.data1;
        check("final_data1", 32'(d1), 32'd9);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
